// File: rtl/ahb_lite_master.sv
// AHB-Lite master: turns one local command into a SINGLE or INCR4 transfer,
// with wait states, two-cycle ERROR handling and per-beat write/read handshakes.
//
// Handshakes:
//   cmd_valid/cmd_ready : command taken on the edge where both are high.
//                         cmd_ready is high only in IDLE.
//   wd_ready            : write-beat address phase accepted this edge. wd_data
//                         is taken on that same edge (no backpressure from local
//                         logic).
//   rd_valid            : one-cycle pulse. rd_data is valid only in that cycle.
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_incr4,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [1:0]            HTRANS,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LAST = 3'd2,
    S_ERR1 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_haddr;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;
  logic [2:0]            r_hburst;
  logic [1:0]            r_htrans;
  logic [DATA_WIDTH-1:0] r_hwdata;
  logic [1:0]            r_acnt;
  logic [1:0]            r_dcnt;
  logic [1:0]            r_nbeat;
  logic                  r_dp_active;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_reject;
  logic                  w_misalign;
  logic                  w_cross;
  logic [ADDR_WIDTH-1:0] w_last_addr;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic                  w_aphase;
  logic                  w_dphase;
  logic                  w_err_first;
  logic                  w_err_final;
  logic                  w_rd_beat;

  assign cmd_ready   = (r_state == S_IDLE);
  assign w_accept    = cmd_valid & cmd_ready;

  // Beat 3 sits 3*size bytes past the start; a 1 KB crossing is illegal in a burst.
  assign w_misalign  = (cmd_addr & ((ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1))) != '0;
  assign w_last_addr = cmd_addr + (ADDR_WIDTH'(3) << cmd_size);
  assign w_cross     = cmd_incr4 & (cmd_addr[ADDR_WIDTH-1:10] != w_last_addr[ADDR_WIDTH-1:10]);
  assign w_reject    = (cmd_size > 3'd2) | w_misalign | w_cross;

  assign w_incr      = ADDR_WIDTH'(1) << r_hsize;
  assign w_aphase    = r_htrans[1] & HREADY;
  assign w_dphase    = r_dp_active & HREADY;
  assign w_err_first = r_dp_active & HRESP & ~HREADY;
  assign w_err_final = r_dp_active & HRESP & HREADY;
  assign w_rd_beat   = w_dphase & ~HRESP & ~r_hwrite &
                       ((r_state == S_ADDR) | (r_state == S_LAST));

  assign wd_ready    = r_htrans[1] & r_hwrite & HREADY;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_reject ? S_DONE : S_ADDR;
      S_ADDR: begin
        if (w_err_first)                           w_next = S_ERR1;
        else if (w_err_final)                      w_next = S_DONE;
        else if (w_aphase && (r_acnt == r_nbeat))  w_next = S_LAST;
      end
      S_LAST: begin
        if (w_err_first)                           w_next = S_ERR1;
        else if (w_err_final)                      w_next = S_DONE;
        else if (w_dphase && (r_dcnt == r_nbeat))  w_next = S_DONE;
      end
      S_ERR1: if (HRESP && HREADY) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= 3'd0;
      r_hburst    <= 3'd0;
      r_htrans    <= HT_IDLE;
      r_hwdata    <= '0;
      r_acnt      <= 2'd0;
      r_dcnt      <= 2'd0;
      r_nbeat     <= 2'd0;
      r_dp_active <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= w_rd_beat;
      if (w_rd_beat) r_rd_data <= HRDATA;
      if (wd_ready)  r_hwdata  <= wd_data;
      // A data phase follows every accepted address phase; ending the command drops it.
      if (w_next == S_DONE)  r_dp_active <= 1'b0;
      else if (HREADY)       r_dp_active <= r_htrans[1];
      if (w_dphase && !HRESP) r_dcnt <= r_dcnt + 2'd1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_err <= w_reject;
            if (!w_reject) begin
              r_haddr  <= cmd_addr;
              r_hwrite <= cmd_write;
              r_hsize  <= cmd_size;
              r_hburst <= cmd_incr4 ? 3'b011 : 3'b000;
              r_htrans <= HT_NONSEQ;
              r_nbeat  <= cmd_incr4 ? 2'd3 : 2'd0;
              r_acnt   <= 2'd0;
              r_dcnt   <= 2'd0;
            end
          end
        end
        S_ADDR: begin
          if (w_err_first || w_err_final) r_err <= 1'b1;
          if ((w_next == S_ERR1) || (w_next == S_DONE)) begin
            r_htrans <= HT_IDLE;
          end else if (w_aphase) begin
            if (w_next == S_LAST) begin
              r_htrans <= HT_IDLE;
            end else begin
              r_htrans <= HT_SEQ;
              r_haddr  <= r_haddr + w_incr;
              r_acnt   <= r_acnt + 2'd1;
            end
          end
        end
        S_LAST: begin
          if (w_err_first || w_err_final) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign HADDR       = r_haddr;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = r_hsize;
  assign HBURST      = r_hburst;
  assign HTRANS      = r_htrans;
  assign HPROT       = 4'b0011;
  assign HMASTLOCK   = 1'b0;
  assign HWDATA      = r_hwdata;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign done        = (r_state == S_DONE);
  assign err         = done & r_err;
  assign o_dbg_state = r_state;

endmodule
